// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_ADJUST = 2'd2
    } sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam int SEC_MAX = 59;

endpackage

// File: rtl/stopwatch_core_bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX back to 00; carry flags an increment taken at MAX.
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = SEC_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    localparam bcd_t MAX_T = 4'(MAX / 10);
    localparam bcd_t MAX_O = 4'(MAX % 10);

    logic at_max;

    assign at_max = (tens == MAX_T) && (ones == MAX_O);
    assign carry  = inc && at_max;

    // clr outranks inc so a same-cycle increment is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == 4'd9) begin
                ones <= '0;
                tens <= tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with run/pause, clear and per-field adjust.
// Optional STOPWATCH_BLINK_EN flashes the field being adjusted via the blank mask.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       blink,
    input  logic       pause_pulse,
    input  logic       clear,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic [3:0] blank
);

    logic tick1_prev, tick2_prev;
    logic tick1_q, tick2_q;
    logic pause_q, clear_q, adj_q, sel_q;

    sw_state_t state_q, state_n;
    logic      saved_run_q, saved_run_n;
    logic      in_adjust;

    logic sec_inc, min_inc, sec_carry;
    logic unused_min_carry;

    // Input stage: rising-edge detect on the tick levels plus one register on every control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick1_prev <= 1'b0;
            tick2_prev <= 1'b0;
            tick1_q    <= 1'b0;
            tick2_q    <= 1'b0;
            pause_q    <= 1'b0;
            clear_q    <= 1'b0;
            adj_q      <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            tick1_prev <= tick_1hz;
            tick2_prev <= tick_2hz;
            tick1_q    <= tick_1hz & ~tick1_prev;
            tick2_q    <= tick_2hz & ~tick2_prev;
            pause_q    <= pause_pulse;
            clear_q    <= clear;
            adj_q      <= adj;
            sel_q      <= sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PAUSED;
            saved_run_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            saved_run_q <= saved_run_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        saved_run_n = saved_run_q;
        case (state_q)
            ST_PAUSED: begin
                if (adj_q) begin
                    state_n     = ST_ADJUST;
                    saved_run_n = 1'b0;
                end else if (pause_q) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                if (adj_q) begin
                    state_n     = ST_ADJUST;
                    saved_run_n = 1'b1;
                end else if (pause_q) begin
                    state_n = ST_PAUSED;
                end
            end
            ST_ADJUST: begin
                // pause_pulse has no effect here; the saved flag picks the exit state.
                if (!adj_q) begin
                    state_n = saved_run_q ? ST_RUN : ST_PAUSED;
                end
            end
            default: state_n = ST_PAUSED;
        endcase
    end

    always_comb begin
        running   = (state_q == ST_RUN);
        in_adjust = (state_q == ST_ADJUST);
    end

    // The seconds carry only reaches minutes while running, never in adjust.
    assign sec_inc = (running && tick1_q) || (in_adjust && tick2_q && sel_q);
    assign min_inc = (running && sec_carry) || (in_adjust && tick2_q && !sel_q);

    bcd_mod_counter #(
        .MAX (SEC_MAX)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (clear_q),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    bcd_mod_counter #(
        .MAX (MAX_MIN)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (clear_q),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (unused_min_carry)
    );

`ifdef STOPWATCH_BLINK_EN
    logic [3:0] blank_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 4'b0000;
        end else if (in_adjust) begin
            blank_q <= sel ? {2'b00, blink, blink} : {blink, blink, 2'b00};
        end else begin
            blank_q <= 4'b0000;
        end
    end

    assign blank = blank_q;
`else
    logic unused_blink;

    assign unused_blink = blink;
    assign blank        = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed table, hand sequences, then random run against a seconds-based model.
module tb_stopwatch_core;

    localparam int MAX_MIN = 59;

    localparam int OP_PAUSE = 0;
    localparam int OP_T1    = 1;
    localparam int OP_T2    = 2;
    localparam int OP_ADJ   = 3;

    localparam int M_PAUSED = 0;
    localparam int M_RUN    = 1;
    localparam int M_ADJ    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, tick_2hz, blink, pause_pulse, clear, adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running;
    logic [3:0] blank;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_core #(
        .MAX_MIN (MAX_MIN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_1hz    (tick_1hz),
        .tick_2hz    (tick_2hz),
        .blink       (blink),
        .pause_pulse (pause_pulse),
        .clear       (clear),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .blank       (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int a;
        int b;
        int em;
        int es;
        bit er;
    } vec_t;

    typedef struct packed {
        logic t1;
        logic t2;
        logic pause;
        logic clr;
        logic adj;
        logic sel;
        logic blink;
    } rvec_t;

    vec_t  tbl[22];
    rvec_t vq[$];

    // Reference model: count held as plain minutes/seconds integers.
    int m_min, m_sec, m_st;
    bit m_saved, m_p1, m_p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int em, input int es, input bit er,
                         input logic [3:0] eb);
        logic [20:0] act, exp;
        act = {min_tens, min_ones, sec_tens, sec_ones, running, blank};
        exp = {4'(em / 10), 4'(em % 10), 4'(es / 10), 4'(es % 10), er, eb};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d%0d:%0d%0d run=%0b blank=%b, want %0d%0d:%0d%0d run=%0b blank=%b",
                     name, min_tens, min_ones, sec_tens, sec_ones, running, blank,
                     em / 10, em % 10, es / 10, es % 10, er, eb);
        end
    endtask

    task automatic apply_op(input int op, input int a, input int b);
        case (op)
            OP_PAUSE: begin
                pause_pulse = 1'b1; step(); pause_pulse = 1'b0; step();
            end
            OP_T1: repeat (a) begin
                tick_1hz = 1'b1; step(); tick_1hz = 1'b0; step();
            end
            OP_T2: repeat (a) begin
                tick_2hz = 1'b1; step(); tick_2hz = 1'b0; step();
            end
            default: begin
                adj = a[0]; sel = b[0]; step(); step();
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {tick_1hz, tick_2hz, blink, pause_pulse, clear, adj, sel} = '0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic model_step(input rvec_t v);
        bit e1, e2;
        int total;
        e1 = v.t1 && !m_p1;
        e2 = v.t2 && !m_p2;
        m_p1 = v.t1;
        m_p2 = v.t2;
        if (v.clr) begin
            m_min = 0;
            m_sec = 0;
        end else if (m_st == M_RUN && e1) begin
            total = (m_min * 60 + m_sec + 1) % ((MAX_MIN + 1) * 60);
            m_min = total / 60;
            m_sec = total % 60;
        end else if (m_st == M_ADJ && e2) begin
            if (v.sel) m_sec = (m_sec + 1) % 60;
            else       m_min = (m_min + 1) % (MAX_MIN + 1);
        end
        if (m_st == M_ADJ) begin
            if (!v.adj) m_st = m_saved ? M_RUN : M_PAUSED;
        end else if (v.adj) begin
            m_saved = (m_st == M_RUN);
            m_st    = M_ADJ;
        end else if (v.pause) begin
            m_st = (m_st == M_RUN) ? M_PAUSED : M_RUN;
        end
    endtask

    function automatic logic [3:0] blank_for(input int st, input logic b, input logic s);
`ifdef STOPWATCH_BLINK_EN
        if (st != M_ADJ) return 4'b0000;
        return s ? {2'b00, b, b} : {b, b, 2'b00};
`else
        return 4'b0000;
`endif
    endfunction

    initial begin
        logic [3:0] exp_blank;
        logic       bl;
        rvec_t      v, cur;
        bit         adj_lvl;

        tbl[0]  = '{OP_PAUSE, 0,  0, 0,  0,  1'b1};
        tbl[1]  = '{OP_T1,    3,  0, 0,  3,  1'b1};
        tbl[2]  = '{OP_ADJ,   1,  1, 0,  3,  1'b0};
        tbl[3]  = '{OP_T2,    56, 0, 0,  59, 1'b0};
        tbl[4]  = '{OP_T1,    2,  0, 0,  59, 1'b0};
        tbl[5]  = '{OP_ADJ,   0,  1, 0,  59, 1'b1};
        tbl[6]  = '{OP_T1,    1,  0, 1,  0,  1'b1};
        tbl[7]  = '{OP_ADJ,   1,  0, 1,  0,  1'b0};
        tbl[8]  = '{OP_T2,    58, 0, 59, 0,  1'b0};
        tbl[9]  = '{OP_ADJ,   1,  1, 59, 0,  1'b0};
        tbl[10] = '{OP_T2,    59, 0, 59, 59, 1'b0};
        tbl[11] = '{OP_T2,    1,  0, 59, 0,  1'b0};
        tbl[12] = '{OP_T2,    59, 0, 59, 59, 1'b0};
        tbl[13] = '{OP_PAUSE, 0,  0, 59, 59, 1'b0};
        tbl[14] = '{OP_ADJ,   0,  0, 59, 59, 1'b1};
        tbl[15] = '{OP_T1,    1,  0, 0,  0,  1'b1};
        tbl[16] = '{OP_PAUSE, 0,  0, 0,  0,  1'b0};
        tbl[17] = '{OP_ADJ,   1,  0, 0,  0,  1'b0};
        tbl[18] = '{OP_T2,    59, 0, 59, 0,  1'b0};
        tbl[19] = '{OP_T2,    1,  0, 0,  0,  1'b0};
        tbl[20] = '{OP_ADJ,   0,  0, 0,  0,  1'b0};
        tbl[21] = '{OP_T1,    1,  0, 0,  0,  1'b0};

        rst_n = 1'b0;
        {tick_1hz, tick_2hz, blink, pause_pulse, clear, adj, sel} = '0;
        #3;
        check("reset_values", 0, 0, 1'b0, 4'b0000);
        step(); step();
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            apply_op(tbl[i].op, tbl[i].a, tbl[i].b);
            check($sformatf("table_%0d", i), tbl[i].em, tbl[i].es, tbl[i].er, 4'b0000);
        end

        // Held tick level gives a single increment.
        apply_op(OP_PAUSE, 0, 0);
        tick_1hz = 1'b1;
        repeat (6) step();
        tick_1hz = 1'b0; step();
        check("held_tick", 0, 1, 1'b1, 4'b0000);

        // Async reset in the middle of a run.
        apply_op(OP_T1, 4, 0);
        rst_n = 1'b0;
        #2;
        check("async_reset", 0, 0, 1'b0, 4'b0000);
        step();
        rst_n = 1'b1;
        step();

        // Load 12:34, run, then clear together with a tick edge.
        apply_op(OP_ADJ, 1, 0);
        apply_op(OP_T2, 12, 0);
        apply_op(OP_ADJ, 1, 1);
        apply_op(OP_T2, 34, 0);
        apply_op(OP_ADJ, 0, 0);
        apply_op(OP_PAUSE, 0, 0);
        check("load_12_34", 12, 34, 1'b1, 4'b0000);
        clear = 1'b1; tick_1hz = 1'b1; step();
        clear = 1'b0; tick_1hz = 1'b0; step();
        check("clear_with_tick", 0, 0, 1'b1, 4'b0000);

        // pause_pulse coinciding with a tick: count then pause.
        apply_op(OP_T1, 5, 0);
        check("run_to_05", 0, 5, 1'b1, 4'b0000);
        pause_pulse = 1'b1; tick_1hz = 1'b1; step();
        pause_pulse = 1'b0; tick_1hz = 1'b0; step();
        check("pause_with_tick", 0, 6, 1'b0, 4'b0000);
        apply_op(OP_T1, 1, 0);
        check("paused_after", 0, 6, 1'b0, 4'b0000);

        // Blank mask while adjusting with a toggling blink level.
        apply_op(OP_ADJ, 1, 0);
        for (int i = 0; i < 8; i++) begin
            bl = 1'($urandom_range(0, 1));
            blink = bl; step();
            check($sformatf("blink_min_%0d", i), 0, 6, 1'b0, blank_for(M_ADJ, bl, 1'b0));
        end
        sel = 1'b1; blink = 1'b1; step();
        check("blink_sec", 0, 6, 1'b0, blank_for(M_ADJ, 1'b1, 1'b1));
        adj = 1'b0; blink = 1'b0; step(); step();
        check("blink_exit", 0, 6, 1'b0, 4'b0000);

        // Randomised run against the model.
        do_reset();
        m_min = 0; m_sec = 0; m_st = M_PAUSED; m_saved = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
        exp_blank = 4'b0000;
        adj_lvl = 1'b0;
        vq.delete();
        for (int i = 0; i < 4000; i++) begin
            if (vq.size() == 2) begin
                v = vq.pop_front();
                model_step(v);
            end
            check($sformatf("rand_%0d", i), m_min, m_sec, m_st == M_RUN, exp_blank);
            if ($urandom_range(0, 39) == 0) adj_lvl = ~adj_lvl;
            cur.t1    = 1'($urandom_range(0, 1));
            cur.t2    = 1'($urandom_range(0, 1));
            cur.pause = ($urandom_range(0, 15) == 0);
            cur.clr   = ($urandom_range(0, 199) == 0);
            cur.adj   = adj_lvl;
            cur.sel   = 1'($urandom_range(0, 1));
            cur.blink = 1'($urandom_range(0, 1));
            exp_blank = blank_for(m_st, cur.blink, cur.sel);
            {tick_1hz, tick_2hz, pause_pulse, clear, adj, sel, blink} = cur;
            vq.push_back(cur);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

MM:SS stopwatch counter sitting directly downstream of the clock divider. It consumes the divider's 1 Hz, 2 Hz and 5 Hz level outputs as in-domain tick sources. It provides run/pause, clear and per-field adjust control, and drives four BCD digits plus a blank mask to the seven-segment display multiplexer.

## Interface
Parameters:
- MAX_MIN, 59, highest minutes value before wrap to 00; legal range 1..99.

Ports:
- clk  input  1  100 MHz master clock, same clock as the divider.
- rst_n  input  1  reset, asynchronous, active-low.
- tick_1hz  input  1  clk_1Hz level from the divider; rising edge = count tick.
- tick_2hz  input  1  clk_2Hz level from the divider; rising edge = adjust tick.
- blink  input  1  clk_5Hz level from the divider; used only when STOPWATCH_BLINK_EN is defined.
- pause_pulse  input  1  one-cycle debounced button pulse; toggles run/pause.
- clear  input  1  one-cycle pulse; zeroes the count.
- adj  input  1  level; 1 = adjust mode.
- sel  input  1  adjust field select: 0 = minutes, 1 = seconds.
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits.
- running  output  1  1 while in RUN.
- blank  output  4  digit blank mask [3:0] = {min_tens, min_ones, sec_tens, sec_ones}.

## Operation
- Edge detect: one flop per tick input holds the previous level. The tick is the cycle where the input is 1 and the flop is 0. Each flop resets to 0.
- States: PAUSED, RUN, ADJUST.
  - Reset enters PAUSED with count 00:00.
  - PAUSED: pause_pulse moves to RUN.
  - RUN: pause_pulse moves to PAUSED.
  - PAUSED or RUN with adj=1: move to ADJUST. A saved run flag records the state being left.
  - ADJUST with adj=0: return to the state given by the saved run flag.
- In ADJUST, pause_pulse is ignored and the saved run flag is unchanged.
- RUN: each 1 Hz tick increments seconds.
  - sec 59 wraps to 00 and carries into minutes.
  - min MAX_MIN with carry wraps to 00.
  - MAX_MIN:59 + 1 gives 00:00.
- PAUSED: ticks are ignored.
- ADJUST: 1 Hz ticks are ignored. Each 2 Hz tick increments only the field selected by sel.
  - seconds: 59 wraps to 00, with no carry into minutes.
  - minutes: MAX_MIN wraps to 00.
  - sel is sampled in the tick cycle.
- Arithmetic: pure BCD.
  - ones digit 9 goes to 0 and increments the tens digit.
  - The wrap check compares the full two-digit value.
  - Digits never hold a value above 9.
- Priority within a cycle: rst_n, then clear, then tick increment, then pause_pulse state change.
  - clear zeroes all digits in any state. The state is unchanged and any same-cycle tick is dropped.
  - pause_pulse together with a 1 Hz tick in RUN: the count increments, and the state is PAUSED from the next cycle.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). Reset deassertion is synchronised by the system; the block does not resynchronise it.

## Timing
- Reset values: all digits 0, running 0, blank 4'b0000, edge flops 0, saved run flag 0.
- Tick latency: a tick input rises and is sampled at edge N. The digits show the new value after edge N+1, i.e. one cycle.
- Control latency: pause_pulse, adj or clear sampled at edge N affects state, running and digits after edge N+1.
- A tick input held high gives exactly one increment; a new increment needs a low cycle first.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- STOPWATCH_BLINK_EN defined:
  - In ADJUST, the selected field's two blank bits equal the registered blink level. sel=0 drives blank[3:2]; sel=1 drives blank[1:0]. The other bits are 0.
  - Outside ADJUST, blank = 0.
  - blank is registered, with one cycle latency from blink or sel.
- STOPWATCH_BLINK_EN undefined: blank is tied to 4'b0000, blink is unused, and no blink logic is synthesised. The port list is identical in both builds.

## Structure
- stopwatch_pkg holds:
  - state encoding (PAUSED, RUN, ADJUST);
  - 4-bit BCD digit type;
  - SEC_MAX = 59 constant.
- Sub-module bcd_mod_counter:
  - two-digit BCD counter with parameter MAX, inputs inc and clr, output carry (asserted when inc occurs at MAX);
  - instanced once for seconds (MAX = 59) and once for minutes (MAX = MAX_MIN).
  - In ADJUST, the seconds carry is gated off from the minutes inc.

## Test plan
- Reset, then pause_pulse, then 3 tick_1hz rising edges: running=1, digits 00:03. Assert rst_n low mid-run: digits 00:00, running 0 asynchronously.
- RUN from 00:59, one 1 Hz tick: 01:00. From 59:59 with MAX_MIN=59, one tick: 00:00.
- adj=1, sel=1 at 00:59, one 2 Hz tick: 00:00 with minutes unchanged. Then sel=0 at 59:xx, one tick: 00:xx. 1 Hz ticks in ADJUST change nothing.
- Enter ADJUST from RUN, then drop adj: running=1 again. Enter from PAUSED: running=0. pause_pulse during ADJUST is ignored.
- clear and tick_1hz edge in the same cycle at 12:34 in RUN: digits 00:00, state stays RUN. pause_pulse with a tick at 00:05: 00:06, then PAUSED.
- STOPWATCH_BLINK_EN defined, ADJUST, sel=0, blink toggling: blank[3:2] follows blink one cycle late, blank[1:0]=0. Without the macro: blank constant 0.
